// File: rtl/avalon_burst_rw_tester.sv
// Avalon-MM burst memory self-test master: pattern write, pipelined
// burst read-back, per-beat compare, error count and read watchdog.
module avalon_burst_rw_tester #(
    parameter int                ADDR_W     = 26,
    parameter int                DATA_W     = 128,
    parameter int                BURST_LEN  = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 26'h3ffffff,
    parameter int                MAX_OUTST  = 4,
    parameter int                TIMEOUT    = 4096,
    parameter logic [31:0]       LFSR_SEED  = 32'h3E0F0E32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic [1:0]        iMODE,
    input  logic [7:0]        iLOOPS,
    input  logic              insert_error,
    input  logic              avl_waitrequest,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata,
    output logic [ADDR_W-1:0] avl_address,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_read,
    output logic              avl_write,
    output logic              avl_burstbegin,
    output logic [6:0]        avl_size,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oPASS,
    output logic              oFAIL,
    output logic              oTIMEOUT,
    output logic [15:0]       oERR_CNT,
    output logic [ADDR_W-1:0] oFAIL_ADDR,
    output logic [7:0]        oLOOP_CNT
);

    localparam int NW   = DATA_W / 32;
    localparam int BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_BURST = END_ADDR - ADDR_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BSTEP      = ADDR_W'(BURST_LEN);
    localparam logic [BW-1:0]     LAST_BEAT  = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [DATA_W-1:0] pat_word(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] a,
        input logic [31:0]       l
    );
        logic [31:0] w;
        case (m)
            2'd0:    w = l;
            2'd1:    w = 32'(a);
            2'd2:    w = a[0] ? 32'hAAAAAAAA : 32'h55555555;
            default: w = ~32'(a);
        endcase
        return {NW{w}};
    endfunction

    state_t            state;
    logic              start_q;
    logic [1:0]        mode_q;
    logic [7:0]        loops_q;
    logic              inj_q;
    logic [ADDR_W-1:0] wr_word;
    logic [BW-1:0]     beat;
    logic [31:0]       lfsr_wr;
    logic [31:0]       lfsr_rd;
    logic [3:0]        outst;
    logic [ADDR_W-1:0] ret_addr;
    logic [BW-1:0]     ret_beat;
    logic [WD_W-1:0]   wd;

    logic              start_edge;
    logic              wr_acc;
    logic              rd_acc;
    logic              rdv_ok;
    logic              rd_last;
    logic [3:0]        outst_nx;
    logic              issue;
    logic              mismatch;
    logic              wd_fire;
    logic [7:0]        next_loop;
    logic              enter_wr;
    logic [1:0]        init_mode;
    logic              init_inj;
    logic [31:0]       init_seed;
    logic [DATA_W-1:0] init_data;
    logic [DATA_W-1:0] nxt_data;

    assign avl_size   = 7'(BURST_LEN);
    assign start_edge = iSTART & ~start_q & ((state == S_IDLE) | (state == S_DONE));
    assign wr_acc     = avl_write & ~avl_waitrequest;
    assign rd_acc     = avl_read & ~avl_waitrequest;
    assign rdv_ok     = avl_readdatavalid & (outst != 4'd0);
    assign rd_last    = rdv_ok & (ret_beat == LAST_BEAT);
    assign outst_nx   = outst + {3'b0, rd_acc} - {3'b0, rd_last};
    assign issue      = outst_nx < 4'(MAX_OUTST);
    assign wd_fire    = (outst != 4'd0) & ~avl_readdatavalid & (wd == WD_W'(TIMEOUT - 1));
    assign next_loop  = oLOOP_CNT + 8'd1;

    // Stray beats with nothing outstanding count as errors while a test runs.
    assign mismatch = oBUSY & avl_readdatavalid &
                      (~rdv_ok | (avl_readdata != pat_word(mode_q, ret_addr, lfsr_rd)));

    assign enter_wr  = start_edge |
                       ((state == S_DRAIN) & (outst == 4'd0) & (next_loop != loops_q));
    assign init_mode = start_edge ? iMODE : mode_q;
    assign init_inj  = start_edge ? insert_error : inj_q;
    assign init_seed = LFSR_SEED ^ (start_edge ? 32'd0 : 32'(next_loop));
    assign init_data = pat_word(init_mode, START_ADDR, init_seed) ^ DATA_W'(init_inj);
    assign nxt_data  = pat_word(mode_q, wr_word + ADDR_W'(1), lfsr_step(lfsr_wr));

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state          <= S_IDLE;
            start_q        <= 1'b0;
            mode_q         <= '0;
            loops_q        <= '0;
            inj_q          <= 1'b0;
            wr_word        <= '0;
            beat           <= '0;
            lfsr_wr        <= '0;
            lfsr_rd        <= '0;
            outst          <= '0;
            ret_addr       <= '0;
            ret_beat       <= '0;
            wd             <= '0;
            avl_address    <= '0;
            avl_writedata  <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_burstbegin <= 1'b0;
            oBUSY          <= 1'b0;
            oDONE          <= 1'b0;
            oPASS          <= 1'b0;
            oFAIL          <= 1'b0;
            oTIMEOUT       <= 1'b0;
            oERR_CNT       <= '0;
            oFAIL_ADDR     <= '0;
            oLOOP_CNT      <= '0;
        end else begin
            start_q <= iSTART;
            outst   <= outst_nx;
            if (rdv_ok) begin
                ret_addr <= ret_addr + ADDR_W'(1);
                ret_beat <= rd_last ? '0 : ret_beat + BW'(1);
                lfsr_rd  <= lfsr_step(lfsr_rd);
            end
            if (mismatch) begin
                if (oERR_CNT != 16'hFFFF) oERR_CNT <= oERR_CNT + 16'd1;
                if (oERR_CNT == 16'd0) oFAIL_ADDR <= ret_addr;
                oFAIL <= 1'b1;
            end
            if (avl_readdatavalid) wd <= '0;
            else if (outst != 4'd0) wd <= wd + WD_W'(1);

            if (wd_fire) begin
                state          <= S_DONE;
                oTIMEOUT       <= 1'b1;
                oFAIL          <= 1'b1;
                oDONE          <= 1'b1;
                oBUSY          <= 1'b0;
                oPASS          <= 1'b0;
                avl_read       <= 1'b0;
                avl_write      <= 1'b0;
                avl_burstbegin <= 1'b0;
                outst          <= '0;
                wd             <= '0;
            end else if (enter_wr) begin
                state          <= S_WRITE;
                avl_write      <= 1'b1;
                avl_burstbegin <= 1'b1;
                avl_address    <= START_ADDR;
                wr_word        <= START_ADDR;
                beat           <= '0;
                lfsr_wr        <= init_seed;
                avl_writedata  <= init_data;
                if (start_edge) begin
                    mode_q     <= iMODE;
                    loops_q    <= (iLOOPS == 8'd0) ? 8'd1 : iLOOPS;
                    inj_q      <= insert_error;
                    oBUSY      <= 1'b1;
                    oDONE      <= 1'b0;
                    oPASS      <= 1'b0;
                    oFAIL      <= 1'b0;
                    oTIMEOUT   <= 1'b0;
                    oERR_CNT   <= '0;
                    oFAIL_ADDR <= '0;
                    oLOOP_CNT  <= '0;
                    outst      <= '0;
                    wd         <= '0;
                end else begin
                    oLOOP_CNT <= next_loop;
                end
            end else begin
                case (state)
                    S_WRITE: if (wr_acc) begin
                        lfsr_wr       <= lfsr_step(lfsr_wr);
                        wr_word       <= wr_word + ADDR_W'(1);
                        avl_writedata <= nxt_data;
                        if (beat == LAST_BEAT) begin
                            beat           <= '0;
                            avl_burstbegin <= 1'b1;
                            if (avl_address == LAST_BURST) begin
                                state       <= S_READ;
                                avl_write   <= 1'b0;
                                avl_read    <= 1'b1;
                                avl_address <= START_ADDR;
                                lfsr_rd     <= LFSR_SEED ^ 32'(oLOOP_CNT);
                                ret_addr    <= START_ADDR;
                                ret_beat    <= '0;
                            end else begin
                                avl_address <= avl_address + BSTEP;
                            end
                        end else begin
                            beat           <= beat + BW'(1);
                            avl_burstbegin <= 1'b0;
                        end
                    end
                    S_READ: begin
                        if (rd_acc && avl_address == LAST_BURST) begin
                            state          <= S_DRAIN;
                            avl_read       <= 1'b0;
                            avl_burstbegin <= 1'b0;
                        end else begin
                            if (rd_acc) avl_address <= avl_address + BSTEP;
                            avl_read       <= issue;
                            avl_burstbegin <= issue;
                        end
                    end
                    S_DRAIN: if (outst == 4'd0) begin
                        oLOOP_CNT <= next_loop;
                        state     <= S_DONE;
                        oDONE     <= 1'b1;
                        oBUSY     <= 1'b0;
                        oPASS     <= ~(oFAIL | mismatch);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avalon_burst_rw_tester.sv
// Directed bench for avalon_burst_rw_tester with a 16-word
// burst memory model (stalls, latency, dropped burst, bit flip).
module tb_avalon_burst_rw_tester;

    logic         iCLK = 1'b0;
    logic         iRST_n = 1'b0;
    logic         iSTART = 1'b0;
    logic [1:0]   iMODE = 2'd0;
    logic [7:0]   iLOOPS = 8'd0;
    logic         insert_error = 1'b0;
    logic         avl_waitrequest = 1'b0;
    logic         avl_readdatavalid = 1'b0;
    logic [127:0] avl_readdata = '0;
    logic [25:0]  avl_address;
    logic [127:0] avl_writedata;
    logic         avl_read, avl_write, avl_burstbegin;
    logic [6:0]   avl_size;
    logic         oBUSY, oDONE, oPASS, oFAIL, oTIMEOUT;
    logic [15:0]  oERR_CNT;
    logic [25:0]  oFAIL_ADDR;
    logic [7:0]   oLOOP_CNT;

    avalon_burst_rw_tester #(
        .ADDR_W(26), .DATA_W(128), .BURST_LEN(4),
        .START_ADDR(26'd0), .END_ADDR(26'd15),
        .MAX_OUTST(2), .TIMEOUT(64), .LFSR_SEED(32'h3E0F0E32)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iMODE(iMODE),
        .iLOOPS(iLOOPS), .insert_error(insert_error),
        .avl_waitrequest(avl_waitrequest),
        .avl_readdatavalid(avl_readdatavalid),
        .avl_readdata(avl_readdata), .avl_address(avl_address),
        .avl_writedata(avl_writedata), .avl_read(avl_read),
        .avl_write(avl_write), .avl_burstbegin(avl_burstbegin),
        .avl_size(avl_size), .oBUSY(oBUSY), .oDONE(oDONE),
        .oPASS(oPASS), .oFAIL(oFAIL), .oTIMEOUT(oTIMEOUT),
        .oERR_CNT(oERR_CNT), .oFAIL_ADDR(oFAIL_ADDR),
        .oLOOP_CNT(oLOOP_CNT)
    );

    always #5 iCLK = ~iCLK;

    int ncmp = 0;
    int nerr = 0;

    int wait_pct = 0, lat = 1, drop_idx = -1, flip_addr = -1;
    int run_id = 0;

    int ecnt = 0;
    int cyc = 0, seen_id = 0;
    int wbeats, rcmds, max_out, out_now, bb_bad, rburst_idx, wbeat;
    int last_valid_edge = 0, cur_addr = 0, cur_rem = 0, a;
    bit got_first;
    logic [127:0] first_wdata;
    logic [127:0] mem [0:15];
    int q_t[$];
    int q_a[$];

    always @(posedge iCLK) ecnt++;

    always @(negedge iCLK) begin
        if (seen_id != run_id) begin
            seen_id = run_id;
            wbeats = 0; rcmds = 0; max_out = 0; out_now = 0;
            bb_bad = 0; rburst_idx = 0; got_first = 1'b0;
        end
        if (!iRST_n) begin
            q_t.delete();
            q_a.delete();
            cur_rem = 0;
            wbeat = 0;
            avl_readdatavalid = 1'b0;
            avl_waitrequest = 1'b0;
        end else begin
            cyc++;
            avl_readdatavalid = 1'b0;
            if (cur_rem == 0 && q_t.size() > 0 && q_t[0] <= cyc) begin
                cur_addr = q_a.pop_front();
                void'(q_t.pop_front());
                cur_rem = 4;
            end
            if (cur_rem > 0) begin
                avl_readdatavalid = 1'b1;
                avl_readdata = mem[cur_addr & 15];
                if (cur_addr == flip_addr) avl_readdata[5] = ~avl_readdata[5];
                last_valid_edge = ecnt + 1;
                cur_addr++;
                cur_rem--;
                if (cur_rem == 0) out_now--;
            end
            avl_waitrequest = ($urandom_range(99) < wait_pct);
            if (avl_write) begin
                if (avl_burstbegin !== (wbeat == 0)) bb_bad++;
            end else if (avl_burstbegin !== avl_read) begin
                bb_bad++;
            end
            if (avl_write && !avl_waitrequest) begin
                a = int'(avl_address) + wbeat;
                mem[a & 15] = avl_writedata;
                if (!got_first) begin
                    first_wdata = avl_writedata;
                    got_first = 1'b1;
                end
                wbeat = (wbeat + 1) % 4;
                wbeats++;
            end
            if (avl_read && !avl_waitrequest) begin
                if (rburst_idx != drop_idx) begin
                    q_t.push_back(cyc + lat);
                    q_a.push_back(int'(avl_address));
                end
                rburst_idx++;
                rcmds++;
                out_now++;
                if (out_now > max_out) max_out = out_now;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [7:0] loops,
                               input logic inj);
        @(negedge iCLK);
        run_id++;
        iMODE = m;
        iLOOPS = loops;
        insert_error = inj;
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!oDONE && n < 6000) begin
            @(negedge iCLK);
            n++;
        end
        chk({tag, "_done"}, oDONE, 1'b1);
    endtask

    int delta;
    int n;

    initial begin
        repeat (2) @(negedge iCLK);
        chk("rst_size", avl_size, 7'd4);
        chk("rst_busy", oBUSY, 1'b0);
        chk("rst_write", avl_write, 1'b0);
        chk("rst_done", oDONE, 1'b0);
        chk("rst_err", oERR_CNT, 16'd0);
        iRST_n = 1'b1;

        // clean LFSR pass, zero wait
        pulse_start(2'd0, 8'd1, 1'b0);
        chk("t1_busy", oBUSY, 1'b1);
        wait_done("t1");
        chk("t1_pass", oPASS, 1'b1);
        chk("t1_fail", oFAIL, 1'b0);
        chk("t1_err", oERR_CNT, 16'd0);
        chk("t1_loops", oLOOP_CNT, 8'd1);
        chk("t1_busy_end", oBUSY, 1'b0);
        chk("t1_wbeats", wbeats, 16);
        chk("t1_rcmds", rcmds, 4);
        chk("t1_first", first_wdata, {4{32'h3E0F0E32}});
        chk("t1_bb", bb_bad, 0);

        // injected error, three passes
        pulse_start(2'd0, 8'd3, 1'b1);
        wait_done("t2");
        chk("t2_err", oERR_CNT, 16'd3);
        chk("t2_fail", oFAIL, 1'b1);
        chk("t2_faddr", oFAIL_ADDR, 26'd0);
        chk("t2_pass", oPASS, 1'b0);
        chk("t2_loops", oLOOP_CNT, 8'd3);
        chk("t2_wbeats", wbeats, 48);
        chk("t2_first", first_wdata, {{3{32'h3E0F0E32}}, 32'h3E0F0E33});

        // bit 5 flipped on readback of word 9, address pattern
        flip_addr = 9;
        pulse_start(2'd1, 8'd1, 1'b0);
        wait_done("t3");
        flip_addr = -1;
        chk("t3_err", oERR_CNT, 16'd1);
        chk("t3_faddr", oFAIL_ADDR, 26'd9);
        chk("t3_pass", oPASS, 1'b0);
        chk("t3_mem5", mem[5], {4{32'd5}});
        chk("t3_mem9", mem[9], {4{32'd9}});

        // random stalls and long latency
        wait_pct = 50;
        lat = 20;
        pulse_start(2'd3, 8'd2, 1'b0);
        wait_done("t4");
        wait_pct = 0;
        chk("t4_maxout", (max_out <= 2), 1'b1);
        chk("t4_bb", bb_bad, 0);
        chk("t4_pass", oPASS, 1'b1);
        chk("t4_loops", oLOOP_CNT, 8'd2);
        chk("t4_mem6", mem[6], {4{~32'd6}});

        // third read burst never returns
        lat = 3;
        drop_idx = 2;
        pulse_start(2'd1, 8'd1, 1'b0);
        wait_done("t5");
        delta = ecnt - last_valid_edge;
        drop_idx = -1;
        chk("t5_tout", oTIMEOUT, 1'b1);
        chk("t5_delta", delta, 64);
        chk("t5_read", avl_read, 1'b0);
        chk("t5_write", avl_write, 1'b0);
        chk("t5_busy", oBUSY, 1'b0);
        chk("t5_fail", oFAIL, 1'b1);
        chk("t5_pass", oPASS, 1'b0);

        // reset during READ, then clean restart
        lat = 20;
        pulse_start(2'd0, 8'd1, 1'b0);
        n = 0;
        while (!avl_read && n < 500) begin
            @(negedge iCLK);
            n++;
        end
        chk("t6_in_read", avl_read, 1'b1);
        iRST_n = 1'b0;
        #1;
        chk("t6_rst_read", avl_read, 1'b0);
        chk("t6_rst_bb", avl_burstbegin, 1'b0);
        chk("t6_rst_busy", oBUSY, 1'b0);
        chk("t6_rst_addr", avl_address, 26'd0);
        chk("t6_rst_loops", oLOOP_CNT, 8'd0);
        chk("t6_rst_size", avl_size, 7'd4);
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b1;
        pulse_start(2'd2, 8'd1, 1'b0);
        wait_done("t6");
        chk("t6_pass", oPASS, 1'b1);
        chk("t6_err", oERR_CNT, 16'd0);
        chk("t6_mem3", mem[3], {4{32'hAAAAAAAA}});
        chk("t6_mem4", mem[4], {4{32'h55555555}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
